// File: rtl/spi_slave_port_pkg.sv
// ----------------------------------------------------------------------------
// spi_slave_port_pkg
// Shared definitions for the register-mapped SPI slave:
//   - CPU register addresses
//   - status / control bit positions and the writable control mask
//   - frame FSM state encoding
//   - helper that assembles the status word from individual flags
// ----------------------------------------------------------------------------
package spi_slave_port_pkg;

   // Register map
   localparam logic [2:0] ADDR_RX     = 3'd0;
   localparam logic [2:0] ADDR_TX     = 3'd1;
   localparam logic [2:0] ADDR_STATUS = 3'd2;
   localparam logic [2:0] ADDR_CTRL   = 3'd3;

   // Status bit positions (control enables share the same positions)
   localparam int SB_ROE  = 3;
   localparam int SB_TOE  = 4;
   localparam int SB_TMT  = 5;
   localparam int SB_TRDY = 6;
   localparam int SB_RRDY = 7;
   localparam int SB_E    = 8;
   localparam int SB_TUR  = 9;

   // Implemented control enable bits: 3,4,6,7,8,9
   localparam logic [15:0] CTRL_MASK = 16'h03D8;

   localparam int CNT_W = 5;   // bit counter, holds 0..16

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2
   } frame_state_t;

   function automatic logic [15:0] pack_status(
      input logic roe,
      input logic toe,
      input logic tmt,
      input logic trdy,
      input logic rrdy,
      input logic tur
   );
      logic [15:0] s;
      s          = '0;
      s[SB_ROE]  = roe;
      s[SB_TOE]  = toe;
      s[SB_TMT]  = tmt;
      s[SB_TRDY] = trdy;
      s[SB_RRDY] = rrdy;
      s[SB_E]    = roe | toe | tur;
      s[SB_TUR]  = tur;
      return s;
   endfunction

endpackage

// File: rtl/spi_slave_port_sync.sv
// ----------------------------------------------------------------------------
// spi_slave_sync
// Multi-flop synchronizer for an asynchronous SPI pin, plus one extra flop
// for edge detection. Rise/fall are single-cycle pulses aligned with the
// first cycle the synchronized level shows the new value.
// Ports:
//   clk      system clock
//   reset    synchronous active-high reset (suppresses edge pulses)
//   i_async  asynchronous pin
//   o_level  synchronized level
//   o_rise   0->1 pulse
//   o_fall   1->0 pulse
// ----------------------------------------------------------------------------
module spi_slave_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_async,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   w_level;

   // The chain keeps tracking the pin through reset, so a pin that is
   // already low when reset releases does not look like a fresh edge.
   always_ff @(posedge clk) begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
   end

   always_ff @(posedge clk) begin
      if (reset) r_prev <= w_level;
      else       r_prev <= w_level;
   end

   assign w_level = r_sync[SYNC_STAGES-1];
   assign o_level = w_level;
   assign o_rise  = ~reset &  w_level & ~r_prev;
   assign o_fall  = ~reset & ~w_level &  r_prev;

endmodule

// File: rtl/spi_slave_port.sv
// ----------------------------------------------------------------------------
// spi_slave_port
// SPI mode-0, MSB-first slave with a CPU register interface.
// Ports:
//   clk, reset                 system clock, sync active-high reset
//   spi_select, mem_addr,      CPU register bus (addr 0 rx, 1 tx,
//   read_n, write_n,           2 status r/w-clear, 3 control)
//   data_from_cpu, data_to_cpu
//   irq                        OR of enabled status bits, registered
//   SCLK, SS_n, MOSI           SPI inputs from the master (asynchronous)
//   MISO, MISO_oe              SPI output and its pad enable
// ----------------------------------------------------------------------------
module spi_slave_port
   import spi_slave_port_pkg::*;
#(
   parameter int DATABITS    = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        spi_select,
   input  logic [2:0]  mem_addr,
   input  logic        read_n,
   input  logic        write_n,
   input  logic [15:0] data_from_cpu,
   output logic [15:0] data_to_cpu,
   output logic        irq,
   input  logic        SCLK,
   input  logic        SS_n,
   input  logic        MOSI,
   output logic        MISO,
   output logic        MISO_oe
);

   // ---------------- pin synchronizers ----------------
   logic w_sclk_rise, w_sclk_fall, w_unused_sclk_lvl;
   logic w_ss_lvl, w_ss_fall, w_unused_ss_rise;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic w_mosi;

   spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk     (clk),
      .reset   (reset),
      .i_async (SCLK),
      .o_level (w_unused_sclk_lvl),
      .o_rise  (w_sclk_rise),
      .o_fall  (w_sclk_fall)
   );

   spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
      .clk     (clk),
      .reset   (reset),
      .i_async (SS_n),
      .o_level (w_ss_lvl),
      .o_rise  (w_unused_ss_rise),
      .o_fall  (w_ss_fall)
   );

   // MOSI goes through the same depth as SCLK so the sample taken on the
   // SCLK rise pulse lines up with the pin value around that edge.
   always_ff @(posedge clk) begin
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
   end
   assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

   // ---------------- CPU access decode ----------------
   logic w_rd, w_wr;
   logic w_rd_rx, w_wr_tx, w_wr_stat, w_wr_ctrl;

   assign w_rd      = spi_select & ~read_n;
   assign w_wr      = spi_select & ~write_n;
   assign w_rd_rx   = w_rd & (mem_addr == ADDR_RX);
   assign w_wr_tx   = w_wr & (mem_addr == ADDR_TX);
   assign w_wr_stat = w_wr & (mem_addr == ADDR_STATUS);
   assign w_wr_ctrl = w_wr & (mem_addr == ADDR_CTRL);

   // ---------------- state ----------------
   frame_state_t r_state, w_next;

   logic [DATABITS-1:0] r_tx_hold, r_tx_shift, r_rx_shift, r_rx_hold;
   logic                r_tx_primed;
   logic [CNT_W-1:0]    r_bit_cnt;
   logic                r_reload;       // last bit done, next SCLK fall reloads
   logic                r_rrdy, r_roe, r_toe, r_tur;
   logic [15:0]         r_ctrl;
   logic [15:0]         r_data_to_cpu;
   logic                r_irq;

   logic                w_load, w_sample, w_shift, w_frame_done;
   logic                w_active;
   logic [DATABITS-1:0] w_rx_next;
   logic [15:0]         w_status;

   // ---------------- frame FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_load   = 1'b0;
      w_sample = 1'b0;
      w_shift  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_ss_fall) w_next = S_LOAD;
         end
         S_LOAD: begin
            w_load = 1'b1;
            w_next = S_SHIFT;
         end
         S_SHIFT: begin
            w_sample = w_sclk_rise;
            if (w_sclk_fall) begin
               // Falling edge after a full frame primes the next one.
               w_load  = r_reload;
               w_shift = ~r_reload;
            end
         end
         default: w_next = S_IDLE;
      endcase
      // Deselect aborts from anywhere; the partial frame has no effect.
      if (r_state != S_IDLE && w_ss_lvl) begin
         w_next   = S_IDLE;
         w_load   = 1'b0;
         w_sample = 1'b0;
         w_shift  = 1'b0;
      end
   end

   assign w_active     = (r_state != S_IDLE);
   assign w_rx_next    = DATABITS'({r_rx_shift, w_mosi});
   assign w_frame_done = w_sample & (r_bit_cnt == CNT_W'(DATABITS - 1));

   // ---------------- datapath and flags ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tx_hold   <= '0;
         r_tx_shift  <= '0;
         r_rx_shift  <= '0;
         r_rx_hold   <= '0;
         r_tx_primed <= 1'b0;
         r_bit_cnt   <= '0;
         r_reload    <= 1'b0;
         r_rrdy      <= 1'b0;
         r_roe       <= 1'b0;
         r_toe       <= 1'b0;
         r_tur       <= 1'b0;
         r_ctrl      <= '0;
      end else begin
         if (!w_active) begin
            r_bit_cnt <= '0;
            r_reload  <= 1'b0;
         end

         // Transmit side: load consumes the holding register (or zeros).
         if (w_load) begin
            r_tx_shift <= r_tx_primed ? r_tx_hold : '0;
            r_bit_cnt  <= '0;
            r_reload   <= 1'b0;
         end else if (w_shift) begin
            r_tx_shift <= r_tx_shift << 1;
         end

         // Receive side
         if (w_sample) begin
            r_rx_shift <= w_rx_next;
            if (w_frame_done) begin
               r_rx_hold <= w_rx_next;
               r_bit_cnt <= '0;
               r_reload  <= 1'b1;
            end else begin
               r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
         end

         // tx holding: a load in the same cycle sees the pre-write state;
         // the write is judged against the pre-load primed flag.
         if (w_load) r_tx_primed <= 1'b0;
         if (w_wr_tx && !r_tx_primed) begin
            r_tx_hold   <= data_from_cpu[DATABITS-1:0];
            r_tx_primed <= 1'b1;
         end

         // Flags: setting events win over the CPU clear.
         if (w_frame_done)              r_rrdy <= 1'b1;
         else if (w_rd_rx || w_wr_stat) r_rrdy <= 1'b0;

         if (w_frame_done && r_rrdy && !w_rd_rx) r_roe <= 1'b1;
         else if (w_wr_stat)                     r_roe <= 1'b0;

         if (w_wr_tx && r_tx_primed) r_toe <= 1'b1;
         else if (w_wr_stat)         r_toe <= 1'b0;

         if (w_load && !r_tx_primed) r_tur <= 1'b1;
         else if (w_wr_stat)         r_tur <= 1'b0;

         if (w_wr_ctrl) r_ctrl <= data_from_cpu & CTRL_MASK;
      end
   end

   assign w_status = pack_status(r_roe, r_toe, ~r_tx_primed & ~w_active,
                                 ~r_tx_primed, r_rrdy, r_tur);

   // ---------------- CPU read data and interrupt ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_data_to_cpu <= '0;
         r_irq         <= 1'b0;
      end else begin
         r_irq <= |(w_status & r_ctrl);
         if (w_rd) begin
            case (mem_addr)
               ADDR_RX:     r_data_to_cpu <= 16'(r_rx_hold);
               ADDR_STATUS: r_data_to_cpu <= w_status;
               ADDR_CTRL:   r_data_to_cpu <= r_ctrl;
               default:     r_data_to_cpu <= '0;
            endcase
         end
      end
   end

   assign data_to_cpu = r_data_to_cpu;
   assign irq         = r_irq;
   assign MISO_oe     = w_active;
   assign MISO        = w_active & r_tx_shift[DATABITS-1];

endmodule

// File: tb/tb_spi_slave_port.sv
module tb_spi_slave_port;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_select = 1'b0;
  logic [2:0]  mem_addr = 3'd0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [15:0] data_from_cpu = 16'h0;
  logic [15:0] data_to_cpu;
  logic        irq;
  logic        SCLK = 1'b0;
  logic        SS_n = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic        MISO_oe;

  spi_slave_port #(.DATABITS(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .spi_select(spi_select), .mem_addr(mem_addr),
    .read_n(read_n), .write_n(write_n), .data_from_cpu(data_from_cpu),
    .data_to_cpu(data_to_cpu), .irq(irq), .SCLK(SCLK), .SS_n(SS_n),
    .MOSI(MOSI), .MISO(MISO), .MISO_oe(MISO_oe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level reference model of the register view
  bit         m_primed;
  logic [7:0] m_hold, m_rx;
  bit         m_rrdy, m_roe, m_toe, m_tur;
  logic [15:0] m_ctrl;

  task automatic model_reset();
    m_primed = 0; m_hold = 8'h0; m_rx = 8'h0;
    m_rrdy = 0; m_roe = 0; m_toe = 0; m_tur = 0; m_ctrl = 16'h0;
  endtask

  // Status as seen while no frame is in progress
  function automatic logic [15:0] m_status();
    logic [15:0] s;
    s = 16'h0;
    s[3] = m_roe; s[4] = m_toe; s[5] = !m_primed; s[6] = !m_primed;
    s[7] = m_rrdy; s[8] = m_roe | m_toe | m_tur; s[9] = m_tur;
    return s;
  endfunction

  function automatic logic m_irq();
    return |(m_status() & m_ctrl);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // All bus activity starts and ends on a falling clock edge.
  task automatic cpu_wr(input logic [2:0] a, input logic [15:0] d);
    spi_select = 1; write_n = 0; mem_addr = a; data_from_cpu = d;
    @(negedge clk);
    spi_select = 0; write_n = 1;
    case (a)
      3'd1: if (!m_primed) begin m_hold = d[7:0]; m_primed = 1; end else m_toe = 1;
      3'd2: begin m_rrdy = 0; m_roe = 0; m_toe = 0; m_tur = 0; end
      3'd3: m_ctrl = d & 16'h03D8;
      default: ;
    endcase
  endtask

  task automatic cpu_rd(input logic [2:0] a, output logic [15:0] d);
    spi_select = 1; read_n = 0; mem_addr = a;
    @(negedge clk);
    spi_select = 0; read_n = 1;
    d = data_to_cpu;
    if (a == 3'd0) m_rrdy = 0;
  endtask

  task automatic rd_chk(input logic [2:0] a, input string tag, input logic [15:0] exp);
    logic [15:0] d;
    cpu_rd(a, d);
    chk(tag, d, exp);
  endtask

  task automatic chk_status(input string tag);
    rd_chk(3'd2, tag, m_status());
  endtask

  task automatic chk_irq(input string tag);
    wait_clk(2);
    chk(tag, 16'(irq), 16'(m_irq()));
  endtask

  // Each frame start and each completed word consumes one tx word.
  task automatic consume(output logic [7:0] w);
    if (m_primed) begin w = m_hold; m_primed = 0; end
    else begin w = 8'h0; m_tur = 1; end
  endtask

  task automatic spi_bits(input logic [7:0] mo, input int nb, output logic [7:0] mi);
    mi = 8'h0;
    for (int i = 0; i < nb; i++) begin
      MOSI = mo[7-i];
      wait_clk(8);
      mi[7-i] = MISO;
      SCLK = 1;
      wait_clk(8);
      SCLK = 0;
    end
  endtask

  task automatic run_frame(input string tag, input int n, input logic [7:0] b0,
                           input logic [7:0] b1, output logic [7:0] first_mi);
    logic [7:0] exp_tx, mi, mo;
    first_mi = 8'h0;
    SS_n = 0;
    consume(exp_tx);
    wait_clk(8);
    for (int k = 0; k < n; k++) begin
      mo = (k == 0) ? b0 : b1;
      spi_bits(mo, 8, mi);
      if (k == 0) first_mi = mi;
      chk({tag, "_miso"}, 16'(mi), 16'(exp_tx));
      if (m_rrdy) m_roe = 1;
      m_rx = mo; m_rrdy = 1;
      consume(exp_tx);
    end
    wait_clk(8);
    SS_n = 1;
    wait_clk(8);
  endtask

  initial begin
    logic [7:0]  mi, b0, b1;
    logic [15:0] d;
    int          op;

    model_reset();
    wait_clk(4);
    chk("rst_data", data_to_cpu, 16'h0);
    chk("rst_irq", 16'(irq), 16'h0);
    chk("rst_miso", 16'(MISO), 16'h0);
    chk("rst_oe", 16'(MISO_oe), 16'h0);
    reset = 0;
    wait_clk(2);
    rd_chk(3'd2, "rst_status", 16'h0060);
    rd_chk(3'd3, "rst_ctrl", 16'h0000);

    // Basic transfer
    cpu_wr(3'd1, 16'h00A5);
    run_frame("t1", 1, 8'h3C, 8'h00, mi);
    chk("t1_txbyte", 16'(mi), 16'h00A5);
    rd_chk(3'd0, "t1_rx", 16'h003C);
    cpu_rd(3'd2, d);
    chk("t1_rrdy_clr", d & 16'h00A0, 16'h0020);
    chk("t1_status", d, m_status());

    // Overrun with interrupt
    cpu_wr(3'd2, 16'h0);
    cpu_wr(3'd3, 16'h0008);
    run_frame("t2", 2, 8'h11, 8'h22, mi);
    chk("t2_irq", 16'(irq), 16'h1);
    cpu_rd(3'd2, d);
    chk("t2_roe", 16'(d[3]), 16'h1);
    chk("t2_status", d, m_status());
    rd_chk(3'd0, "t2_rx", 16'h0022);

    // Underrun
    cpu_wr(3'd2, 16'h0);
    cpu_wr(3'd3, 16'h0);
    run_frame("t3", 1, 8'h96, 8'h00, mi);
    chk("t3_txzero", 16'(mi), 16'h0000);
    cpu_rd(3'd2, d);
    chk("t3_tur_e", d & 16'h0300, 16'h0300);
    cpu_wr(3'd2, 16'hFFFF);
    rd_chk(3'd2, "t3_cleared", 16'h0060);

    // Tx overwrite
    cpu_wr(3'd1, 16'h0001);
    cpu_wr(3'd1, 16'h0002);
    cpu_rd(3'd2, d);
    chk("t4_toe", 16'(d[4]), 16'h1);
    run_frame("t4", 1, 8'h00, 8'h00, mi);
    chk("t4_txbyte", 16'(mi), 16'h0001);
    rd_chk(3'd0, "t4_rx", 16'h0000);

    // Partial frame
    cpu_wr(3'd2, 16'h0);
    SS_n = 0;
    consume(b0);
    wait_clk(8);
    spi_bits(8'hF0, 5, mi);
    wait_clk(8);
    chk("t5_oe_on", 16'(MISO_oe), 16'h1);
    SS_n = 1;
    wait_clk(3);
    chk("t5_oe_off", 16'(MISO_oe), 16'h0);
    wait_clk(8);
    chk_status("t5_status");
    rd_chk(3'd0, "t5_rx_keep", 16'h0000);

    // Reset mid-frame
    cpu_wr(3'd3, 16'h0200);
    SS_n = 0;
    consume(b0);
    wait_clk(8);
    chk_irq("t6_irq_pre");
    spi_bits(8'hC3, 4, mi);
    reset = 1;
    @(negedge clk);
    model_reset();
    chk("t6_oe", 16'(MISO_oe), 16'h0);
    chk("t6_miso", 16'(MISO), 16'h0);
    chk("t6_irq", 16'(irq), 16'h0);
    chk("t6_data", data_to_cpu, 16'h0);
    reset = 0;
    wait_clk(4);
    chk("t6_oe_hold", 16'(MISO_oe), 16'h0);
    rd_chk(3'd2, "t6_status", 16'h0060);
    SS_n = 1;
    wait_clk(8);
    cpu_wr(3'd1, 16'h00E7);
    run_frame("t6", 1, 8'h5A, 8'h00, mi);
    rd_chk(3'd0, "t6_rx", 16'h005A);

    // Randomized traffic against the model
    for (int it = 0; it < 30; it++) begin
      op = $urandom_range(0, 5);
      case (op)
        0: cpu_wr(3'd1, 16'($urandom));
        1: begin
          b0 = 8'($urandom); b1 = 8'($urandom);
          run_frame("rnd", $urandom_range(1, 2), b0, b1, mi);
        end
        2: rd_chk(3'd0, "rnd_rx", 16'(m_rx));
        3: chk_status("rnd_status");
        4: cpu_wr(3'd2, 16'($urandom));
        default: cpu_wr(3'd3, 16'($urandom));
      endcase
      chk_irq("rnd_irq");
    end
    chk_status("final_status");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
